// File: rtl/cam_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_ctrl_pkg
// Brief    : Shared op/mode encodings and FSM state type for the CAM search
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cam_ctrl_pkg;

  localparam logic [1:0] OP_WRITE    = 2'b00;
  localparam logic [1:0] OP_UPDATE   = 2'b01;
  localparam logic [1:0] OP_SEARCH   = 2'b10;
  localparam logic [1:0] OP_RSVD_ACC = 2'b11;

  localparam logic [2:0] MODE_WRITE  = 3'b000;
  localparam logic [2:0] MODE_UPDATE = 3'b001;
  localparam logic [2:0] MODE_CMP1   = 3'b010;
  localparam logic [2:0] MODE_CMP2   = 3'b100;

  // Wide enough for up to 8 pairs plus the one-past-last index.
  localparam int PAIR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_SR_ISSUE = 3'd3,
    ST_SR_CAPT  = 3'd4,
    ST_RESP     = 3'd5
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/cam_pair_decode.sv
`default_nettype none
// ============================================================================
// Module   : cam_pair_decode
// Brief    : Turns key-bit pair k into one subarray compare op (or a skip).
// Revision : 1.0 - initial release
// ============================================================================
module cam_pair_decode
  import cam_ctrl_pkg::*;
#(
  parameter int KEY_BITS = 8
) (
  input  logic [4:0]          base_i,
  input  logic [PAIR_W-1:0]   k_i,
  input  logic [KEY_BITS-1:0] key_i,
  input  logic [KEY_BITS-1:0] care_i,
  output logic [2:0]          mode_o,
  output logic [9:0]          cmp_addr_o,
  output logic [1:0]          cmp_data_o,
  output logic                skip_o
);

  logic [PAIR_W:0] shamt;
  logic [1:0]      key_pair;
  logic [1:0]      care_pair;
  logic [4:0]      row0;
  logic [4:0]      row1;

  always_comb begin
    shamt     = {k_i, 1'b0};
    // Shifting past the key leaves zero care bits, so an out-of-range k skips.
    key_pair  = 2'(key_i >> shamt);
    care_pair = 2'(care_i >> shamt);
    row0      = base_i + shamt;
    row1      = row0 + 5'd1;

    mode_o     = MODE_WRITE;
    cmp_addr_o = '0;
    cmp_data_o = '0;
    skip_o     = 1'b0;
    case (care_pair)
      2'b11: begin
        mode_o     = MODE_CMP2;
        cmp_addr_o = {row1, row0};
        cmp_data_o = key_pair;
      end
      2'b01: begin
        mode_o     = MODE_CMP1;
        cmp_addr_o = {5'd0, row0};
        cmp_data_o = {1'b0, key_pair[0]};
      end
      2'b10: begin
        mode_o     = MODE_CMP1;
        cmp_addr_o = {5'd0, row1};
        cmp_data_o = {1'b0, key_pair[1]};
      end
      default: skip_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cam_exp_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cam_exp_search_ctrl
// Brief    : Write/update/exponent-search sequencer for one 16-column CAM
//            subarray. Optional macro CAM_CTRL_OR_ACC_EN adds op 11
//            search-accumulate (OR of results across searches).
// Revision : 1.0 - initial release
// ============================================================================
module cam_exp_search_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int KEY_BITS   = 8,
  parameter int NUM_ROWS   = 32,
  parameter int TAG_W      = 16,
  parameter int WR_TIMEOUT = 4
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [4:0]          cmd_row,
  input  logic [TAG_W-1:0]    cmd_data,
  input  logic [TAG_W-1:0]    cmd_mask,
  input  logic                cmd_bit,
  input  logic [KEY_BITS-1:0] cmd_key,
  input  logic [KEY_BITS-1:0] cmd_care,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                rsp_err,
  output logic                cam_chip_enable,
  output logic                cam_addr_select,
  output logic                cam_update_signal,
  output logic                cam_acc_en,
  output logic [2:0]          cam_operation_mode,
  output logic [9:0]          cam_cmp_addr,
  output logic [3:0]          cam_ppg_addr,
  output logic [1:0]          cam_cmp_data,
  output logic [1:0]          cam_ppg_data,
  output logic [TAG_W-1:0]    cam_data_in,
  output logic [TAG_W-1:0]    cam_tag_in,
  input  logic [TAG_W-1:0]    cam_tag_out,
  input  logic                cam_write_done
);

  localparam int NUM_PAIRS = KEY_BITS / 2;
  localparam int CNT_W     = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;

  ctrl_state_e         state_q;
  logic [4:0]          row_q;
  logic [KEY_BITS-1:0] key_q;
  logic [KEY_BITS-1:0] care_q;
  logic [PAIR_W-1:0]   k_q;
  logic [TAG_W-1:0]    tag_acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                skip_q;
  logic                rsp_valid_q;
  logic [TAG_W-1:0]    rsp_tag_q;
  logic                rsp_err_q;
  logic                ce_q;
  logic [2:0]          mode_q;
  logic [9:0]          cmp_addr_q;
  logic [1:0]          cmp_data_q;
  logic [TAG_W-1:0]    data_in_q;
  logic [TAG_W-1:0]    tag_in_q;
  logic                upd_q;

  logic                w_idle;
  logic                w_accept;
  logic                w_sr_op;
  logic                w_in_range;
  logic                w_last;
  logic                w_issue;
  logic                w_finish;
  logic [PAIR_W-1:0]   w_dec_k;
  logic [4:0]          w_dec_base;
  logic [KEY_BITS-1:0] w_dec_key;
  logic [KEY_BITS-1:0] w_dec_care;
  logic [2:0]          w_mode;
  logic [9:0]          w_addr;
  logic [1:0]          w_data;
  logic                w_skip;
  logic [TAG_W-1:0]    w_search_res;
  logic [TAG_W-1:0]    w_final_tag;

  assign w_idle     = (state_q == ST_IDLE);
  assign cmd_ready  = w_idle & ~rsp_valid_q;
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_in_range = (int'(cmd_row) + KEY_BITS - 1) < NUM_ROWS;
  assign w_last     = (k_q == PAIR_W'(NUM_PAIRS - 1));

  // Outputs are registered, so the decoder looks at the pair about to be issued.
  assign w_dec_k    = w_idle ? '0 : k_q + PAIR_W'(1);
  assign w_dec_base = w_idle ? cmd_row : row_q;
  assign w_dec_key  = w_idle ? cmd_key : key_q;
  assign w_dec_care = w_idle ? cmd_care : care_q;

  cam_pair_decode #(
    .KEY_BITS (KEY_BITS)
  ) u_pair_decode (
    .base_i     (w_dec_base),
    .k_i        (w_dec_k),
    .key_i      (w_dec_key),
    .care_i     (w_dec_care),
    .mode_o     (w_mode),
    .cmp_addr_o (w_addr),
    .cmp_data_o (w_data),
    .skip_o     (w_skip)
  );

  assign w_issue  = (w_idle && w_accept && w_sr_op && w_in_range)
                 || (state_q == ST_SR_ISSUE && skip_q && !w_last)
                 || (state_q == ST_SR_CAPT && !w_last);
  assign w_finish = ((state_q == ST_SR_ISSUE && skip_q) || state_q == ST_SR_CAPT) && w_last;

  assign w_search_res = (state_q == ST_SR_CAPT) ? (tag_acc_q & cam_tag_out) : tag_acc_q;

`ifdef CAM_CTRL_OR_ACC_EN
  logic             is_acc_q;
  logic [TAG_W-1:0] acc_q;

  assign w_sr_op     = (cmd_op == OP_SEARCH) || (cmd_op == OP_RSVD_ACC);
  assign w_final_tag = is_acc_q ? (w_search_res | acc_q) : w_search_res;

  always_ff @(posedge CLK) begin
    if (rst) begin
      is_acc_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      if (w_accept) is_acc_q <= (cmd_op == OP_RSVD_ACC);
      if (w_finish) acc_q <= w_final_tag;
    end
  end
`else
  assign w_sr_op     = (cmd_op == OP_SEARCH);
  assign w_final_tag = w_search_res;
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      key_q       <= '0;
      care_q      <= '0;
      k_q         <= '0;
      tag_acc_q   <= '0;
      cnt_q       <= '0;
      skip_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      ce_q        <= 1'b0;
      mode_q      <= MODE_WRITE;
      cmp_addr_q  <= '0;
      cmp_data_q  <= '0;
      data_in_q   <= '0;
      tag_in_q    <= '0;
      upd_q       <= 1'b0;
    end else begin
      // Subarray pins idle at zero except during a one-cycle issue.
      ce_q       <= 1'b0;
      mode_q     <= MODE_WRITE;
      cmp_addr_q <= '0;
      cmp_data_q <= '0;
      data_in_q  <= '0;
      tag_in_q   <= '0;
      upd_q      <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            row_q     <= cmd_row;
            key_q     <= cmd_key;
            care_q    <= cmd_care;
            k_q       <= '0;
            tag_acc_q <= '1;
            cnt_q     <= '0;
            if (cmd_op == OP_WRITE) begin
              state_q    <= ST_WR_ISSUE;
              ce_q       <= 1'b1;
              mode_q     <= MODE_WRITE;
              cmp_addr_q <= {5'd0, cmd_row};
              data_in_q  <= cmd_data;
            end else if (cmd_op == OP_UPDATE) begin
              state_q    <= ST_WR_ISSUE;
              ce_q       <= 1'b1;
              mode_q     <= MODE_UPDATE;
              cmp_addr_q <= {5'd0, cmd_row};
              tag_in_q   <= cmd_mask;
              upd_q      <= cmd_bit;
            end else if (w_sr_op && w_in_range) begin
              state_q <= ST_SR_ISSUE;
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_tag_q   <= '0;
            end
          end
        end
        ST_WR_ISSUE: state_q <= ST_WR_WAIT;
        ST_WR_WAIT: begin
          if (cam_write_done) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_tag_q   <= '0;
          end else if (cnt_q == CNT_W'(WR_TIMEOUT - 1)) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_tag_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_SR_ISSUE: begin
          if (skip_q) begin
            if (!w_last) k_q <= k_q + PAIR_W'(1);
          end else begin
            state_q <= ST_SR_CAPT;
          end
        end
        ST_SR_CAPT: begin
          tag_acc_q <= w_search_res;
          if (!w_last) begin
            k_q     <= k_q + PAIR_W'(1);
            state_q <= ST_SR_ISSUE;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (w_issue) begin
        ce_q       <= ~w_skip;
        mode_q     <= w_mode;
        cmp_addr_q <= w_addr;
        cmp_data_q <= w_data;
        skip_q     <= w_skip;
      end

      if (w_finish) begin
        state_q     <= ST_RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b0;
        rsp_tag_q   <= w_final_tag;
      end
    end
  end

  assign rsp_valid          = rsp_valid_q;
  assign rsp_tag            = rsp_tag_q;
  assign rsp_err            = rsp_err_q;
  assign cam_chip_enable    = ce_q;
  assign cam_operation_mode = mode_q;
  assign cam_cmp_addr       = cmp_addr_q;
  assign cam_cmp_data       = cmp_data_q;
  assign cam_data_in        = data_in_q;
  assign cam_tag_in         = tag_in_q;
  assign cam_update_signal  = upd_q;
  assign cam_addr_select    = 1'b0;
  assign cam_acc_en         = 1'b0;
  assign cam_ppg_addr       = '0;
  assign cam_ppg_data       = '0;

endmodule
`default_nettype wire
